// File: rtl/nor_pkg.sv
// Shared definitions for the NOR-only serial logic unit: function codes and FSM states.
package nor_pkg;

    localparam logic [2:0] OP_NOR     = 3'd0;
    localparam logic [2:0] OP_OR      = 3'd1;
    localparam logic [2:0] OP_NA_OR_B = 3'd2;
    localparam logic [2:0] OP_A_OR_NB = 3'd3;
    localparam logic [2:0] OP_AND     = 3'd4;
    localparam logic [2:0] OP_NAND    = 3'd5;
    localparam logic [2:0] OP_XOR     = 3'd6;
    localparam logic [2:0] OP_XNOR    = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/nor_func_cell.sv
// One-bit, eight-function logic cell built exclusively from 2-input NOR gates.
// node[0..7] hold the eight candidate functions in op-code order; node[8..14]
// form a binary 8:1 mux tree (op[0] at the leaves, op[2] at the root).
module nor_func_cell (
    output logic       y,
    input  logic       a,
    input  logic       b,
    input  logic [2:0] op
);

    wire        na;
    wire        nb;
    wire        t_na_or_b;
    wire        t_a_or_nb;
    wire [14:0] node;
    wire [2:0]  opn;

    nor g_na      (na, a, a);
    nor g_nb      (nb, b, b);

    nor g_nor     (node[0], a, b);
    nor g_or      (node[1], node[0], node[0]);
    nor g_t2      (t_na_or_b, na, b);
    nor g_na_or_b (node[2], t_na_or_b, t_na_or_b);
    nor g_t3      (t_a_or_nb, a, nb);
    nor g_a_or_nb (node[3], t_a_or_nb, t_a_or_nb);
    nor g_and     (node[4], na, nb);
    nor g_nand    (node[5], node[4], node[4]);
    // a^b is high when neither "both low" nor "both high"
    nor g_xor     (node[6], node[0], node[4]);
    nor g_xnor    (node[7], node[6], node[6]);

    for (genvar j = 0; j < 3; j++) begin : g_opn
        nor g_inv (opn[j], op[j], op[j]);
    end

    // mux m picks node[2m] (select low) or node[2m+1] (select high) into node[8+m]
    for (genvar m = 0; m < 7; m++) begin : g_mux
        localparam int SEL = (m < 4) ? 0 : ((m < 6) ? 1 : 2);
        wire nx;
        wire ny;
        wire t0;
        wire t1;
        wire o;
        nor g_nx (nx, node[2*m], node[2*m]);
        nor g_ny (ny, node[2*m+1], node[2*m+1]);
        nor g_t0 (t0, op[SEL], nx);
        nor g_t1 (t1, opn[SEL], ny);
        nor g_o  (o, t0, t1);
        nor g_y  (node[8+m], o, o);
    end

    assign y = node[14];

endmodule

// File: rtl/nor_serial_logic_unit.sv
// Multi-cycle two-operand logic unit: evaluates LANES bits per clock, LSB first,
// through NOR-only function cells, with a start/busy/done handshake.
module nor_serial_logic_unit
    import nor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s
);

    localparam int N = WIDTH / LANES;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if (WIDTH < 1 || LANES < 1 || LANES > WIDTH || (WIDTH % LANES) != 0) begin : g_bad_params
        $error("nor_serial_logic_unit: LANES must be 1..WIDTH and divide WIDTH");
    end

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [LANES-1:0] lane_y;
    logic             last;

    // Operand registers shift right each RUN cycle, so the active lanes are always the low bits.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        nor_func_cell u_cell (
            .y  (lane_y[l]),
            .a  (a_q[l]),
            .b  (b_q[l]),
            .op (op_q)
        );
    end

    // New lane results enter at the top; after N shifts the first lane lands at bit 0.
    assign acc_next = (acc >> LANES) | (WIDTH'(lane_y) << (WIDTH - LANES));
    assign last     = (cnt == CNT_LAST);
    assign busy     = (state_q == ST_RUN);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept start only when idle, return after the last lane group
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latches, lane counter, accumulator and the visible result/done registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            acc  <= '0;
            s    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q  <= a;
                        b_q  <= b;
                        op_q <= op;
                        cnt  <= '0;
                        acc  <= '0;
                    end
                end
                ST_RUN: begin
                    a_q <= a_q >> LANES;
                    b_q <= b_q >> LANES;
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        s    <= acc_next;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
